// File: rtl/ec_serial_pkg.sv
// rtl/ec_serial_pkg.sv - shared state encoding and counter-width helper for the serial link blocks
package ec_serial_pkg;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_SHIFT = 1'b1;

   // Smallest width that can hold n distinct values; never below 1 bit.
   function automatic int clog2_ceil(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/ec_serial_word_tx.sv
// rtl/ec_serial_word_tx.sv - parallel word to MSB-first bit stream; ECTX_PARITY_EN appends even parity
module ec_serial_word_tx #(
   parameter int WORD_WIDTH = 574
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic [WORD_WIDTH-1:0] word_in,
   input  logic                  word_in_valid,
   output logic                  word_in_ready,
   output logic                  bit_out,
   output logic                  bit_out_valid,
   output logic                  bit_out_last,
   output logic                  busy
);
   import ec_serial_pkg::*;

`ifdef ECTX_PARITY_EN
   localparam int FRAME_LEN = WORD_WIDTH + 1;
`else
   localparam int FRAME_LEN = WORD_WIDTH;
`endif
   localparam int              CNT_W    = clog2_ceil(FRAME_LEN);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_LEN - 1);

   logic                  state_q, state_d;
   logic [WORD_WIDTH-1:0] sreg_q, sreg_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  last_w;
   logic                  accept_w;

`ifdef ECTX_PARITY_EN
   logic parity_q, parity_d;
`endif

   assign last_w        = (state_q == ST_SHIFT) && (cnt_q == '0);
   assign word_in_ready = ~clr & ((state_q == ST_IDLE) | last_w);
   assign accept_w      = word_in_valid & word_in_ready;

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
`ifdef ECTX_PARITY_EN
      parity_d = parity_q;
`endif
      if (clr) begin
         state_d = ST_IDLE;
         sreg_d  = '0;
         cnt_d   = '0;
`ifdef ECTX_PARITY_EN
         parity_d = 1'b0;
`endif
      end else if (accept_w) begin
         // Reload on the last bit keeps consecutive frames gap-free.
         state_d = ST_SHIFT;
         sreg_d  = word_in;
         cnt_d   = CNT_LOAD;
`ifdef ECTX_PARITY_EN
         parity_d = ^word_in;
`endif
      end else if (state_q == ST_SHIFT) begin
         sreg_d = {sreg_q[WORD_WIDTH-2:0], 1'b0};
         if (last_w) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
`ifdef ECTX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
`ifdef ECTX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   // Outputs come only from registers so the link pin has no path from the inputs.
`ifdef ECTX_PARITY_EN
   assign bit_out = (state_q == ST_SHIFT) & (last_w ? parity_q : sreg_q[WORD_WIDTH-1]);
`else
   assign bit_out = (state_q == ST_SHIFT) & sreg_q[WORD_WIDTH-1];
`endif
   assign bit_out_valid = (state_q == ST_SHIFT);
   assign bit_out_last  = last_w;
   assign busy          = (state_q == ST_SHIFT);

endmodule
